// File: rtl/debounce_pkg.sv
// Package: debounce_pkg
// Shared encodings and defaults for the debounce scheduler slice.
//   trk_state_t : per-button tracker states (2-bit encoding, 2'b11 unused)
//   tmr_state_t : shared debounce timer states
//   DEBOUNCE_CYCLES_DEFAULT : default quiet time in clk cycles
package debounce_pkg;

    typedef enum logic [1:0] {
        TRK_HIGH = 2'b00,   // button released and idle
        TRK_LOW  = 2'b01,   // button seen pressed, waiting for release
        TRK_REQ  = 2'b10    // released, requesting / owning the timer
    } trk_state_t;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } tmr_state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 32'd1200000;

endpackage

// File: rtl/debounce_scheduler_btn_tracker.sv
// Module: btn_tracker
// One button's press/release tracker. Goes LOW on a press, REQ on the
// following release, and returns to HIGH when the shared timer reports a
// completed quiet period for this button.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   btn       : button level, active-low (0 = pressed)
//   is_owner  : this button currently owns the running timer
//   done      : timer completion for this button (this edge)
//   req       : tracker is in REQ
module btn_tracker
    import debounce_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic is_owner,
    input  logic done,
    output logic req
);

    trk_state_t state_r;
    trk_state_t state_next_s;

    // Tracker state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= TRK_HIGH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Tracker next-state logic; completion overrides everything.
    always_comb begin
        state_next_s = state_r;
        if (done) begin
            state_next_s = TRK_HIGH;
        end else begin
            case (state_r)
                TRK_HIGH: state_next_s = btn ? TRK_HIGH : TRK_LOW;
                TRK_LOW:  state_next_s = btn ? TRK_REQ  : TRK_LOW;
                // The owner bouncing low keeps its request; the timer restarts instead.
                TRK_REQ:  state_next_s = (!btn && !is_owner) ? TRK_LOW : TRK_REQ;
                default:  state_next_s = TRK_HIGH;
            endcase
        end
    end

    // Decoded straight from the state flop, so it is glitch-free.
    assign req = (state_r == TRK_REQ);

endmodule

// File: rtl/debounce_scheduler.sv
// Module: debounce_scheduler
// N_BTN buttons share one debounce timer. Released buttons request the
// timer; it is granted round-robin and must see DEBOUNCE_CYCLES quiet
// (high) cycles on the owner before a one-cycle press pulse is emitted.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   btn_n     : raw buttons, active-low
//   press     : registered one-cycle pulse per debounced press-and-release
//   busy      : shared timer is owned
//   grant_id  : current or most recent timer owner
// Build option: define BTN_SYNC_EN to insert a two-flop synchronizer
// (reset value 1) on every btn_n bit, adding two cycles of latency.
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter  int N_BTN           = 4,
    parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter  int CNT_W           = 21,
    localparam int GW              = (N_BTN > 1) ? $clog2(N_BTN) : 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] press,
    output logic             busy,
    output logic [GW-1:0]    grant_id
);

    logic [N_BTN-1:0] btn_s;
    logic [N_BTN-1:0] req_s;
    logic [N_BTN-1:0] is_owner_s;
    logic [N_BTN-1:0] done_s;
    logic             owner_btn_s;
    logic             found_s;
    logic [GW-1:0]    pick_s;

    tmr_state_t       tmr_state_r;
    tmr_state_t       tmr_next_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic [GW-1:0]    grant_r;
    logic [GW-1:0]    grant_next_s;
    logic [GW-1:0]    rr_r;
    logic [GW-1:0]    rr_next_s;
    logic [N_BTN-1:0] press_r;
    logic             busy_r;

`ifdef BTN_SYNC_EN
    logic [N_BTN-1:0] sync1_r;
    logic [N_BTN-1:0] sync2_r;

    // Two-flop synchronizer; resets to released so no false press appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= {N_BTN{1'b1}};
            sync2_r <= {N_BTN{1'b1}};
        end else begin
            sync1_r <= btn_n;
            sync2_r <= sync1_r;
        end
    end

    assign btn_s = sync2_r;
`else
    assign btn_s = btn_n;
`endif

    for (genvar k = 0; k < N_BTN; k++) begin : g_trk
        assign is_owner_s[k] = (tmr_state_r == T_RUN) && (grant_r == GW'(k));

        btn_tracker u_trk (
            .clk      (clk),
            .rst      (rst),
            .btn      (btn_s[k]),
            .is_owner (is_owner_s[k]),
            .done     (done_s[k]),
            .req      (req_s[k])
        );
    end

    assign owner_btn_s = btn_s[grant_r];

    // Round-robin pick: first requester at or after rr_r, wrapping.
    always_comb begin
        int unsigned idx_s;
        found_s = 1'b0;
        pick_s  = {GW{1'b0}};
        idx_s   = 0;
        for (int i = 0; i < N_BTN; i++) begin
            idx_s = (int'(rr_r) + i) % N_BTN;
            if (!found_s && req_s[idx_s]) begin
                found_s = 1'b1;
                pick_s  = GW'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Timer next-state, count and completion logic.
    always_comb begin
        tmr_next_s   = tmr_state_r;
        count_next_s = count_r;
        grant_next_s = grant_r;
        rr_next_s    = rr_r;
        done_s       = {N_BTN{1'b0}};
        case (tmr_state_r)
            T_IDLE: begin
                if (found_s) begin
                    tmr_next_s   = T_RUN;
                    grant_next_s = pick_s;
                    count_next_s = {CNT_W{1'b0}};
                end else begin
                    tmr_next_s = T_IDLE;
                end
            end
            T_RUN: begin
                if (!owner_btn_s) begin
                    // Owner bounced: restart the quiet period, keep the grant.
                    count_next_s = {CNT_W{1'b0}};
                end else if (count_r >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    // ">=" so a corrupted count can never run past the limit.
                    done_s[grant_r] = 1'b1;
                    rr_next_s       = (grant_r == GW'(N_BTN - 1)) ? {GW{1'b0}} : grant_r + 1'b1;
                    tmr_next_s      = T_IDLE;
                end else begin
                    count_next_s = count_r + 1'b1;
                end
            end
            default: begin
                tmr_next_s   = T_IDLE;
                count_next_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // Timer state, scheduler pointers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_state_r <= T_IDLE;
            count_r     <= {CNT_W{1'b0}};
            grant_r     <= {GW{1'b0}};
            rr_r        <= {GW{1'b0}};
            press_r     <= {N_BTN{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            tmr_state_r <= tmr_next_s;
            count_r     <= count_next_s;
            grant_r     <= grant_next_s;
            rr_r        <= rr_next_s;
            press_r     <= done_s;
            busy_r      <= (tmr_next_s == T_RUN);
        end
    end

    assign press    = press_r;
    assign busy     = busy_r;
    assign grant_id = grant_r;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Testbench for debounce_scheduler (N_BTN=4, DEBOUNCE_CYCLES=8).
// Table of timed vectors, directed multi-cycle sequences, then random
// button activity compared against a behavioural model.
module tb_debounce_scheduler;

    localparam int NB  = 4;
    localparam int DEB = 8;

    logic          clk;
    logic          rst;
    logic [NB-1:0] btn_n;
    logic [NB-1:0] press;
    logic          busy;
    logic [1:0]    grant_id;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model: a button is "armed" once seen low and "pending"
    // once released; the timer needs DEB consecutive high samples of its owner.
    bit [NB-1:0] m_seen;
    bit [NB-1:0] m_pend;
    bit [NB-1:0] m_press;
    int          m_run;
    int          m_owner;
    int          m_quiet;
    int          m_rr;

    typedef struct {
        logic          rst;
        logic [NB-1:0] btn;
        int            cycles;
        logic [NB-1:0] exp_press;
        logic          exp_busy;
        logic [1:0]    exp_grant;
    } vec_t;

    vec_t tbl[$];

    debounce_scheduler #(
        .N_BTN           (NB),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_n    (btn_n),
        .press    (press),
        .busy     (busy),
        .grant_id (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_seen  = '0;
        m_pend  = '0;
        m_press = '0;
        m_run   = 0;
        m_owner = 0;
        m_quiet = 0;
        m_rr    = 0;
    endtask

    task automatic model_step();
        bit [NB-1:0] b;
        bit [NB-1:0] old_pend;
        bit [NB-1:0] done;
        int          old_run;
        int          old_owner;
        b         = btn_n;
        old_pend  = m_pend;
        old_run   = m_run;
        old_owner = m_owner;
        done      = '0;
        m_press   = '0;
        if (rst) begin
            model_reset();
            return;
        end
        if (old_run != 0) begin
            if (!b[old_owner]) m_quiet = 0;
            else begin
                m_quiet++;
                if (m_quiet == DEB) begin
                    done[old_owner] = 1'b1;
                    m_press = done;
                    m_run   = 0;
                    m_rr    = (old_owner + 1) % NB;
                end
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                int k;
                k = (m_rr + i) % NB;
                if (old_pend[k]) begin
                    m_run   = 1;
                    m_owner = k;
                    m_quiet = 0;
                    break;
                end
            end
        end
        for (int k = 0; k < NB; k++) begin
            if (done[k]) begin
                m_seen[k] = 1'b0;
                m_pend[k] = 1'b0;
            end else if (m_pend[k]) begin
                if (!b[k] && !(old_run != 0 && old_owner == k)) begin
                    m_pend[k] = 1'b0;
                    m_seen[k] = 1'b1;
                end
            end else if (m_seen[k]) begin
                if (b[k]) begin
                    m_seen[k] = 1'b0;
                    m_pend[k] = 1'b1;
                end
            end else if (!b[k]) begin
                m_seen[k] = 1'b1;
            end
        end
    endtask

    // One clock: inputs were driven before the edge, outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_press(input int budget, output int idx, output int t);
        idx = -1;
        t   = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (press != '0) begin
                check("press_onehot", $countones(press), 1);
                for (int k = NB - 1; k >= 0; k--) if (press[k]) idx = k;
                t = cyc;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            cnt += $countones(press);
        end
    endtask

    // Press the buttons in mask low for two cycles, then release them together.
    task automatic press_release(input logic [NB-1:0] mask);
        btn_n = ~mask;
        tick();
        tick();
        btn_n = '1;
    endtask

    task automatic wait_busy(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (busy) begin
                t = cyc;
                break;
            end
        end
    endtask

    initial begin
        int idx, t1, t2, t3, tg, cnt;
        rst   = 1'b1;
        btn_n = '1;
        model_reset();

        // Single press on button 1, then a held button 0, then a button held across reset release.
        tbl.push_back('{1'b1, 4'b1111,   2, 4'b0000, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 4'b1111,   2, 4'b0000, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 4'b1101,   3, 4'b0000, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 4'b1111,   1, 4'b0000, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 4'b1111,   1, 4'b0000, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 4'b1111,   7, 4'b0000, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 4'b1111,   1, 4'b0010, 1'b0, 2'd1});
        tbl.push_back('{1'b0, 4'b1111,   1, 4'b0000, 1'b0, 2'd1});
        tbl.push_back('{1'b0, 4'b1110, 100, 4'b0000, 1'b0, 2'd1});
        tbl.push_back('{1'b0, 4'b1111,   1, 4'b0000, 1'b0, 2'd1});
        tbl.push_back('{1'b0, 4'b1111,   1, 4'b0000, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 4'b1111,   8, 4'b0001, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 4'b1111,   1, 4'b0000, 1'b0, 2'd0});
        tbl.push_back('{1'b1, 4'b0111,   2, 4'b0000, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 4'b0111,   1, 4'b0000, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 4'b1111,   1, 4'b0000, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 4'b1111,   1, 4'b0000, 1'b1, 2'd3});
        tbl.push_back('{1'b0, 4'b1111,   8, 4'b1000, 1'b0, 2'd3});

        foreach (tbl[i]) begin
            rst   = tbl[i].rst;
            btn_n = tbl[i].btn;
            for (int c = 0; c < tbl[i].cycles; c++) tick();
            check($sformatf("vec%0d_press", i), press,    tbl[i].exp_press);
            check($sformatf("vec%0d_busy",  i), busy,     tbl[i].exp_busy);
            check($sformatf("vec%0d_grant", i), grant_id, tbl[i].exp_grant);
        end

        // Simultaneous release of 0, 2, 3 from a fresh reset: served in index order.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        press_release(4'b1101);
        wait_press(40, idx, t1);
        check("simul_first", idx, 0);
        wait_press(40, idx, t2);
        check("simul_second", idx, 2);
        wait_press(40, idx, t3);
        check("simul_third", idx, 3);
        // Pulse-to-pulse span counted inclusively.
        check("simul_gap_a", ((t2 - t1 + 1) >= 10), 1);
        check("simul_gap_b", ((t3 - t2 + 1) >= 10), 1);

        // Pointer now at 0 after serving 3: 0 beats 3.
        press_release(4'b1001);
        wait_press(40, idx, t1);
        check("rr_after3_first", idx, 0);
        wait_press(40, idx, t1);
        check("rr_after3_second", idx, 3);
        // Serve 0 alone, pointer moves to 1: now 3 beats 0.
        press_release(4'b0001);
        wait_press(40, idx, t1);
        check("rr_solo0", idx, 0);
        press_release(4'b1001);
        wait_press(40, idx, t1);
        check("rr_after0_first", idx, 3);
        wait_press(40, idx, t1);
        check("rr_after0_second", idx, 0);

        // Bounce on the owner at count 5 restarts the quiet period.
        press_release(4'b0001);
        wait_busy(5, tg);
        check("bounce_grant", grant_id, 0);
        count_pulses(5, cnt);
        btn_n = 4'b1110;
        tick();
        btn_n = 4'b1111;
        check("bounce_pre_pulses", cnt, 0);
        check("bounce_busy_held", busy, 1);
        wait_press(20, idx, t1);
        check("bounce_press_id", idx, 0);
        check("bounce_press_time", t1 - tg, 6 + DEB);
        count_pulses(20, cnt);
        check("bounce_single", cnt, 0);

        // Reset at count 4 for button 2 aborts without a pulse.
        press_release(4'b0100);
        wait_busy(5, tg);
        check("rstrun_grant", grant_id, 2);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        #1;
        check("rstrun_press", press, 0);
        check("rstrun_busy", busy, 0);
        check("rstrun_grant0", grant_id, 0);
        model_reset();
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        count_pulses(20, cnt);
        check("rstrun_no_press", cnt, 0);
        press_release(4'b0100);
        wait_press(20, idx, t1);
        check("rstrun_recover", idx, 2);

        // Random activity against the model.
        rst   = 1'b1;
        btn_n = '1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 599) == 0);
            for (int k = 0; k < NB; k++)
                if ($urandom_range(0, 11) == 0) btn_n[k] = ~btn_n[k];
            tick();
            check("rand_press", press, m_press);
            check("rand_busy", busy, m_run);
            check("rand_grant", grant_id, m_owner);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
